// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core, DMA and memory-side signals around the shared data-memory port.
// The arbiter takes the slave modport; the requesters and memory together form the master side.
interface dmem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  cpu_req_valid;
    logic                  cpu_req_ready;
    logic [31:0]           cpu_req_addr;
    logic [3:0]            cpu_req_we;
    logic [31:0]           cpu_req_wdata;
    logic                  cpu_resp_valid;
    logic [31:0]           cpu_resp_data;

    logic                  dma_req_valid;
    logic                  dma_req_ready;
    logic [31:0]           dma_req_addr;
    logic [3:0]            dma_req_we;
    logic [31:0]           dma_req_wdata;
    logic                  dma_resp_valid;
    logic [31:0]           dma_resp_data;

    logic                  mem_en;
    logic [3:0]            mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_din;
    logic [31:0]           mem_dout;

    modport slave (
        input  cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        input  dma_req_valid, dma_req_addr, dma_req_we, dma_req_wdata,
        output dma_req_ready, dma_resp_valid, dma_resp_data,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data,
        output dma_req_valid, dma_req_addr, dma_req_we, dma_req_wdata,
        input  dma_req_ready, dma_resp_valid, dma_resp_data,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single-ported data memory: core has priority,
// a streak counter forces a DMA grant so the loader cannot be starved.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    dmem_port_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] streak;
    logic       force_dma;
    logic       cpu_gnt;
    logic       dma_gnt;
    logic       pend_cpu;
    logic       pend_dma;
    logic       granted_read;

    assign force_dma         = (streak >= LIMIT);
    assign bus.cpu_req_ready = !(force_dma && bus.dma_req_valid);
    assign bus.dma_req_ready = !bus.cpu_req_valid || force_dma;
    assign cpu_gnt           = bus.cpu_req_valid && bus.cpu_req_ready;
    assign dma_gnt           = bus.dma_req_valid && bus.dma_req_ready && !cpu_gnt;

    always_comb begin
        bus.mem_en   = cpu_gnt || dma_gnt;
        bus.mem_we   = 4'h0;
        bus.mem_addr = bus.cpu_req_addr[ADDR_WIDTH+1:2];
        bus.mem_din  = bus.cpu_req_wdata;
        granted_read = 1'b0;
        if (cpu_gnt) begin
            bus.mem_we   = bus.cpu_req_we;
            granted_read = (bus.cpu_req_we == 4'h0);
        end else if (dma_gnt) begin
            bus.mem_we   = bus.dma_req_we;
            bus.mem_addr = bus.dma_req_addr[ADDR_WIDTH+1:2];
            bus.mem_din  = bus.dma_req_wdata;
            granted_read = (bus.dma_req_we == 4'h0);
        end
    end

    // Streak saturates at the limit; any DMA grant or idle DMA side clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= 4'd0;
        end else if (cpu_gnt && bus.dma_req_valid) begin
            streak <= (streak >= LIMIT) ? LIMIT : streak + 4'd1;
        end else if (dma_gnt || !bus.dma_req_valid) begin
            streak <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cpu <= 1'b0;
            pend_dma <= 1'b0;
        end else begin
            pend_cpu <= granted_read && cpu_gnt;
            pend_dma <= granted_read && dma_gnt;
        end
    end

    // Masking with rst drops a read that is still in flight when reset arrives.
    assign bus.cpu_resp_valid = pend_cpu && !rst;
    assign bus.dma_resp_valid = pend_dma && !rst;
    assign bus.cpu_resp_data  = bus.cpu_resp_valid ? bus.mem_dout : 32'h0;
    assign bus.dma_resp_data  = bus.dma_resp_valid ? bus.mem_dout : 32'h0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.cpu_req_addr[1:0], bus.cpu_req_addr[31:ADDR_WIDTH+2],
                                bus.dma_req_addr[1:0], bus.dma_req_addr[31:ADDR_WIDTH+2]};
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: vector table plus starvation and reset sequences,
// with a second instance at STARVE_LIMIT = 1 watching for strict alternation.
module tb_dmem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_WIDTH(14)) bus0 ();
    dmem_port_arbiter_if #(.ADDR_WIDTH(14)) bus1 ();

    dmem_port_arbiter #(.ADDR_WIDTH(14), .STARVE_LIMIT(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    dmem_port_arbiter #(.ADDR_WIDTH(14), .STARVE_LIMIT(1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    assign bus1.cpu_req_valid = bus0.cpu_req_valid;
    assign bus1.cpu_req_addr  = bus0.cpu_req_addr;
    assign bus1.cpu_req_we    = bus0.cpu_req_we;
    assign bus1.cpu_req_wdata = bus0.cpu_req_wdata;
    assign bus1.dma_req_valid = bus0.dma_req_valid;
    assign bus1.dma_req_addr  = bus0.dma_req_addr;
    assign bus1.dma_req_we    = bus0.dma_req_we;
    assign bus1.dma_req_wdata = bus0.dma_req_wdata;
    assign bus1.mem_dout      = 32'h0;

    // Synchronous byte-write memory with one-cycle read latency.
    logic [31:0] mem [0:16383];
    initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (bus0.mem_en) begin
            if (bus0.mem_we == 4'h0) begin
                bus0.mem_dout <= mem[bus0.mem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus0.mem_we[b]) mem[bus0.mem_addr][8*b +: 8] <= bus0.mem_din[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        cv;
        logic [31:0] ca;
        logic [3:0]  cwe;
        logic [31:0] cwd;
        logic        dv;
        logic [31:0] da;
        logic [3:0]  dwe;
        logic [31:0] dwd;
        logic        e_cr;
        logic        e_dr;
        logic        e_en;
        logic [3:0]  e_we;
        logic [13:0] e_addr;
        logic        e_crv;
        logic [31:0] e_crd;
        logic        e_drv;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs [16];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic cv, input logic [31:0] ca, input logic [3:0] cwe,
                                  input logic [31:0] cwd, input logic dv, input logic [31:0] da,
                                  input logic [3:0] dwe, input logic [31:0] dwd);
        bus0.cpu_req_valid = cv;
        bus0.cpu_req_addr  = ca;
        bus0.cpu_req_we    = cwe;
        bus0.cpu_req_wdata = cwd;
        bus0.dma_req_valid = dv;
        bus0.dma_req_addr  = da;
        bus0.dma_req_we    = dwe;
        bus0.dma_req_wdata = dwd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev_c;
        logic prev_d;
        logic exp_c;

        vecs[0]  = '{1'b1, 32'h10000010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 4'hF, 14'd4, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h10000010, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 4'h0, 14'd4, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b1, 1'b0, 4'h0, 14'd0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0,
                     1'b1, 1'b1, 1'b1, 4'hF, 14'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 4'hF, 32'hB1B1B1B1,
                     1'b1, 1'b1, 1'b1, 4'hF, 14'd1, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 4'hF, 32'hC2C2C2C2,
                     1'b1, 1'b1, 1'b1, 4'hF, 14'd2, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b1, 1'b1, 4'h0, 14'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 4'h0, 32'h0,
                     1'b1, 1'b1, 1'b1, 4'h0, 14'd1, 1'b0, 32'h0, 1'b1, 32'hA0A0A0A0};
        vecs[8]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h8, 4'h0, 32'h0,
                     1'b1, 1'b1, 1'b1, 4'h0, 14'd2, 1'b0, 32'h0, 1'b1, 32'hB1B1B1B1};
        vecs[9]  = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b1, 1'b0, 4'h0, 14'd0, 1'b0, 32'h0, 1'b1, 32'hC2C2C2C2};
        vecs[10] = '{1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 4'hF, 14'd8, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h20, 4'h2, 32'h0000AB00, 1'b0, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 4'h2, 14'd8, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 4'h0, 14'd8, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b0, 1'b1, 4'h0, 14'd4, 1'b1, 32'h1122AB44, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b1, 1'b1, 4'h0, 14'd0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0,
                     1'b1, 1'b1, 1'b0, 4'h0, 14'd0, 1'b0, 32'h0, 1'b1, 32'hA0A0A0A0};

        apply_stimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        next_cycle();
        next_cycle();
        check_output("reset_cpu_resp_valid", 32'(bus0.cpu_resp_valid), 32'h0);
        check_output("reset_dma_resp_valid", 32'(bus0.dma_resp_valid), 32'h0);
        check_output("reset_cpu_resp_data", bus0.cpu_resp_data, 32'h0);
        check_output("reset_dma_resp_data", bus0.dma_resp_data, 32'h0);
        check_output("reset_streak", 32'(dut.streak), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].cv, vecs[i].ca, vecs[i].cwe, vecs[i].cwd,
                           vecs[i].dv, vecs[i].da, vecs[i].dwe, vecs[i].dwd);
            #2;
            check_output($sformatf("v%0d_cpu_ready", i), 32'(bus0.cpu_req_ready), 32'(vecs[i].e_cr));
            check_output($sformatf("v%0d_dma_ready", i), 32'(bus0.dma_req_ready), 32'(vecs[i].e_dr));
            check_output($sformatf("v%0d_mem_en", i), 32'(bus0.mem_en), 32'(vecs[i].e_en));
            check_output($sformatf("v%0d_mem_we", i), 32'(bus0.mem_we), 32'(vecs[i].e_we));
            if (vecs[i].e_en)
                check_output($sformatf("v%0d_mem_addr", i), 32'(bus0.mem_addr), 32'(vecs[i].e_addr));
            check_output($sformatf("v%0d_cpu_resp_valid", i), 32'(bus0.cpu_resp_valid), 32'(vecs[i].e_crv));
            check_output($sformatf("v%0d_dma_resp_valid", i), 32'(bus0.dma_resp_valid), 32'(vecs[i].e_drv));
            if (vecs[i].e_crv)
                check_output($sformatf("v%0d_cpu_resp_data", i), bus0.cpu_resp_data, vecs[i].e_crd);
            if (vecs[i].e_drv)
                check_output($sformatf("v%0d_dma_resp_data", i), bus0.dma_resp_data, vecs[i].e_drd);
            next_cycle();
        end

        // Both sides reading continuously: limit 4 gives C,C,C,C,D; limit 1 alternates.
        prev_c = 1'b0;
        prev_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b1, 32'h10, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);
            #2;
            exp_c = ((k % 5) != 4);
            check_output($sformatf("starve%0d_cpu_ready", k), 32'(bus0.cpu_req_ready), 32'(exp_c));
            check_output($sformatf("starve%0d_dma_ready", k), 32'(bus0.dma_req_ready), 32'(!exp_c));
            check_output($sformatf("starve%0d_mem_addr", k), 32'(bus0.mem_addr), exp_c ? 32'd4 : 32'd0);
            check_output($sformatf("starve%0d_cpu_resp_valid", k), 32'(bus0.cpu_resp_valid), 32'(prev_c));
            check_output($sformatf("starve%0d_dma_resp_valid", k), 32'(bus0.dma_resp_valid), 32'(prev_d));
            if (prev_c)
                check_output($sformatf("starve%0d_cpu_resp_data", k), bus0.cpu_resp_data, 32'hDEADBEEF);
            if (prev_d) begin
                check_output($sformatf("starve%0d_dma_resp_data", k), bus0.dma_resp_data, 32'hA0A0A0A0);
                check_output($sformatf("starve%0d_streak_cleared", k), 32'(dut.streak), 32'h0);
            end
            check_output($sformatf("limit1_%0d_cpu_ready", k), 32'(bus1.cpu_req_ready), 32'((k % 2) == 0));
            prev_c = exp_c;
            prev_d = !exp_c;
            next_cycle();
        end

        // Core read with DMA waiting (streak becomes nonzero), then reset kills the response.
        apply_stimulus(1'b1, 32'h20, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);
        #2;
        check_output("pre_reset_cpu_ready", 32'(bus0.cpu_req_ready), 32'h1);
        check_output("pre_reset_dma_resp_valid", 32'(bus0.dma_resp_valid), 32'h1);
        check_output("pre_reset_dma_resp_data", bus0.dma_resp_data, 32'hA0A0A0A0);
        next_cycle();
        check_output("pre_reset_streak", 32'(dut.streak), 32'h1);
        rst = 1'b1;
        apply_stimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h4, 4'h0, 32'h0);
        #2;
        check_output("in_reset_cpu_resp_valid", 32'(bus0.cpu_resp_valid), 32'h0);
        check_output("in_reset_dma_resp_valid", 32'(bus0.dma_resp_valid), 32'h0);
        next_cycle();
        rst = 1'b0;
        apply_stimulus(1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        #2;
        check_output("post_reset_streak", 32'(dut.streak), 32'h0);
        check_output("post_reset_cpu_resp_valid", 32'(bus0.cpu_resp_valid), 32'h0);
        check_output("post_reset_dma_resp_valid", 32'(bus0.dma_resp_valid), 32'h0);
        check_output("post_reset_cpu_ready", 32'(bus0.cpu_req_ready), 32'h1);
        check_output("post_reset_mem_en", 32'(bus0.mem_en), 32'h1);
        check_output("post_reset_mem_addr", 32'(bus0.mem_addr), 32'd8);
        next_cycle();
        apply_stimulus(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        #2;
        check_output("post_reset_read_valid", 32'(bus0.cpu_resp_valid), 32'h1);
        check_output("post_reset_read_data", bus0.cpu_resp_data, 32'h1122AB44);
        check_output("post_reset_dma_quiet", 32'(bus0.dma_resp_valid), 32'h0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single synchronous data-memory port (1-cycle read latency, byte write enables) between two requesters: the core's load/store path and a DMA-style requester (for example a UART program loader).
- The core has fixed priority. A starvation guard forces a DMA grant after a configurable number of consecutive core grants that happen while DMA is waiting.
- Read data is routed back to the requester that issued the read, one cycle later. The core-side byte/halfword extraction stays downstream of this block.

Parameters:
- ADDR_WIDTH, 14, word-address width driven to the memory (memory depth = 2^ADDR_WIDTH words).
- STARVE_LIMIT, 4, consecutive core grants with DMA pending before DMA is forced. Legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cpu_req_valid  input  1  core request present.
- cpu_req_ready  output  1  core request accepted this cycle (when valid).
- cpu_req_addr  input  32  core byte address.
- cpu_req_we  input  4  core byte write enables; 0 means read.
- cpu_req_wdata  input  32  core write data, already lane-aligned.
- cpu_resp_valid  output  1  core read data valid.
- cpu_resp_data  output  32  core read data (full word).
- dma_req_valid  input  1  DMA request present.
- dma_req_ready  output  1  DMA request accepted.
- dma_req_addr  input  32  DMA byte address.
- dma_req_we  input  4  DMA byte write enables; 0 means read.
- dma_req_wdata  input  32  DMA write data.
- dma_resp_valid  output  1  DMA read data valid.
- dma_resp_data  output  32  DMA read data.
- mem_en  output  1  memory enable.
- mem_we  output  4  memory byte write enables.
- mem_addr  output  ADDR_WIDTH  memory word address.
- mem_din  output  32  memory write data.
- mem_dout  input  32  memory read data, valid the cycle after mem_en with mem_we = 0.

Behaviour:
- Clock/reset: single clock clk. rst is synchronous and active-high.
- Reset values: streak counter = 0, pending-read register = none, cpu_resp_valid = 0, dma_resp_valid = 0, resp_data outputs = 0.
- Derived signals:
  - force_dma = (streak >= STARVE_LIMIT).
  - cpu_req_ready = !(force_dma && dma_req_valid).
  - dma_req_ready = !cpu_req_valid || force_dma.
  - Both are combinational from inputs and state. At most one requester is granted per cycle.
- Grant:
  - cpu_gnt = cpu_req_valid && cpu_req_ready.
  - dma_gnt = dma_req_valid && dma_req_ready && !cpu_gnt.
- Memory drive (combinational):
  - mem_en = cpu_gnt || dma_gnt.
  - mem_addr = granted addr[ADDR_WIDTH+1:2].
  - mem_we = granted we.
  - mem_din = granted wdata.
  - When nothing is granted, mem_we = 0 and mem_addr/mem_din are don't-care.
- Address handling: bits [1:0] and all bits above ADDR_WIDTH+1 are ignored. Region decode is done upstream.
- Streak counter (registered):
  - If cpu_gnt && dma_req_valid: streak = min(streak + 1, STARVE_LIMIT).
  - Else if dma_gnt or !dma_req_valid: streak = 0.
  - Else: hold.
- Pending read:
  - On a grant with we == 0, register the owner (CPU or DMA) for the next cycle.
  - Next cycle, the owner's resp_valid = 1 for exactly one cycle and its resp_data = mem_dout. The other requester's resp_valid = 0.
  - Writes produce no response. Write-then-read of the same address on consecutive cycles returns the new data.
- Throughput:
  - Back-to-back grants every cycle. Read latency is exactly 1 cycle from acceptance.
  - A read accepted in cycle N and another in cycle N+1 yield responses in N+1 and N+2.
- Simultaneous valid: the core wins unless force_dma is set, in which case DMA wins and streak clears.
- Boundary at STARVE_LIMIT = 1: grants alternate whenever both requesters are continuously valid.
- Reset mid-operation: a read accepted in the cycle rst is high, or still pending when rst asserts, produces no response.
- Requester obligation: hold valid/addr/we/wdata stable until ready. The arbiter does not latch ungranted requests.

Test Plan:
- Reset, then core writes 0xDEADBEEF (we = 4'hF) to 0x10000010, then reads 0x10000010 -> mem_we = 4'hF and mem_addr = 4 in the write cycle; cpu_resp_valid = 1 with cpu_resp_data = 0xDEADBEEF exactly 1 cycle after the read is accepted; dma_resp_valid stays 0.
- Core and DMA both valid continuously, STARVE_LIMIT = 4 -> grant pattern C,C,C,C,D repeating; streak reads 0 after every DMA grant.
- DMA only, 3 consecutive reads of words 0, 1, 2 -> dma_req_ready = 1 every cycle; dma_resp_valid = 1 for 3 consecutive cycles with the matching words.
- Interleaved: core read accepted in cycle N, DMA read in N+1 -> cpu_resp_valid only in N+1, dma_resp_valid only in N+2, each carrying its own data.
- Byte write we = 4'b0010, wdata = 0x0000AB00 over a word holding 0x11223344, then read -> 0x1122AB44.
- rst asserted in the cycle after a read is accepted -> no resp_valid on either side; streak = 0; next request is granted normally.
